// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 types, pixel width and default line timing
//
// Shared by the WS2812 receiver and transmitter.
//   ws2812_state_e : receiver decode states (SYNC, IDLE, HIGH, LOW)
//   PIX_W          : bits per pixel word
//   DEF_*          : default timing constants in clock cycles at 50 MHz
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } ws2812_state_e;

    localparam int PIX_W            = 24;
    localparam int DEF_CLK_FRE      = 50_000_000;
    localparam int DEF_BIT_THRESH   = 31;
    localparam int DEF_MIN_HIGH     = 10;
    localparam int DEF_MAX_HIGH     = 100;
    localparam int DEF_RESET_CYCLES = DEF_CLK_FRE / 20_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// rtl/ws2812_edge_sync.sv - two-flop synchronizer with rise/fall detect
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears all flops
//   din  : asynchronous serial input
//   ds   : synchronized input
//   rise : ds is high this cycle and was low the previous cycle
//   fall : ds is low this cycle and was high the previous cycle
module ws2812_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ds   = sync_q[1];
    assign rise = sync_q[1] & ~prev_q;
    assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 serial line decoder producing 24-bit pixel words
//
// Optional macro WS2812_RX_ERR_EN enables the sticky err flag; without it
// err is tied low and the error tracking logic is not built.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   din        : asynchronous WS2812 serial line
//   pix_data   : last completed pixel, first wire bit in bit 0
//   pix_valid  : one-cycle strobe, pix_data/pix_index valid
//   pix_index  : pixel position in the current frame, 0-based, wraps at 512
//   frame_done : one-cycle strobe on a reset gap after at least one bit
//   busy       : high from the first rising edge of a frame until frame_done
//   err        : sticky error (glitch, overlong pulse, partial pixel)
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FRE      = DEF_CLK_FRE,
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int MAX_HIGH     = DEF_MAX_HIGH,
    parameter int RESET_CYCLES = CLK_FRE / 20_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic [8:0]        pix_index,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    // One counter serves SYNC/HIGH/LOW since only one is live at a time.
    localparam int CNT_MAX = max_int(RESET_CYCLES, MAX_HIGH + 1);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_MIN   = CW'(MIN_HIGH);
    localparam logic [CW-1:0] C_MAX   = CW'(MAX_HIGH);
    localparam logic [CW-1:0] C_SAT   = CW'(MAX_HIGH + 1);
    localparam logic [CW-1:0] C_THR   = CW'(BIT_THRESH);
    localparam logic [CW-1:0] C_RESET = CW'(RESET_CYCLES);
    localparam logic [4:0]    LAST_BIT = 5'(PIX_W - 1);

    logic ds, rise, fall;

    ws2812_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .ds   (ds),
        .rise (rise),
        .fall (fall)
    );

    ws2812_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [PIX_W-2:0] shift_q, shift_d;      // bits of the pixel so far, newest at top
    logic [PIX_W-1:0] pix_data_q, pix_data_d;
    logic             pix_valid_q, pix_valid_d;
    logic [8:0]       pix_index_q, pix_index_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             seen_q, seen_d;        // at least one bit accepted this frame
    logic             bit_ok, bit_val;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        pix_index_d  = pix_index_q;
        frame_done_d = 1'b0;
        busy_d       = busy_q;
        seen_d       = seen_q;
        bit_ok       = 1'b0;
        bit_val      = 1'b0;

        if (pix_valid_q) begin
            pix_index_d = pix_index_q + 9'd1;
        end

        unique case (state_q)
            ST_SYNC: begin
                if (ds) begin
                    cnt_d = '0;
                end else if (cnt_q >= C_RESET) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    cnt_d   = C_ONE;
                    busy_d  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                    cnt_d   = C_ONE;
                    if (cnt_q >= C_MIN && cnt_q <= C_MAX) begin
                        bit_ok  = 1'b1;
                        bit_val = (cnt_q >= C_THR);
                    end
                end else if (cnt_q < C_SAT) begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    cnt_d   = C_ONE;
                end else if (cnt_q >= C_RESET && !pix_valid_q) begin
                    // Held off while pix_valid is out so frame_done follows it.
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    bitcnt_d     = '0;
                    pix_index_d  = '0;
                    busy_d       = 1'b0;
                    frame_done_d = seen_q;
                    seen_d       = 1'b0;
                end else if (cnt_q < C_RESET) begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (bit_ok) begin
            seen_d = 1'b1;
            if (bitcnt_q == LAST_BIT) begin
                pix_data_d  = {bit_val, shift_q};
                pix_valid_d = 1'b1;
                bitcnt_d    = '0;
            end else begin
                shift_d  = {bit_val, shift_q[PIX_W-2:1]};
                bitcnt_d = bitcnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_index_q  <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            seen_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_index_q  <= pix_index_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            seen_q       <= seen_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_index  = pix_index_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef WS2812_RX_ERR_EN
    logic err_q, err_d;
    logic ferr_q, ferr_d;    // an error occurred somewhere in the current frame

    always_comb begin
        err_d  = err_q;
        ferr_d = ferr_q;
        if (state_q == ST_HIGH && fall && (cnt_q < C_MIN || cnt_q > C_MAX)) begin
            err_d  = 1'b1;
            ferr_d = 1'b1;
        end
        if (state_q == ST_LOW && state_d == ST_IDLE) begin
            ferr_d = 1'b0;
            if (frame_done_d) begin
                err_d = ferr_q || (bitcnt_q != 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            ferr_q <= ferr_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx
module tb_ws2812_rx;

    localparam int MIN_H = 10;
    localparam int MAX_H = 100;
    localparam int THR   = 31;
`ifdef WS2812_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [8:0]  pix_index;
    logic        frame_done;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] got_data[$];
    int          got_idx[$];
    int          got_frames = 0;

    always @(negedge clk) begin
        if (pix_valid) begin
            got_data.push_back(pix_data);
            got_idx.push_back(int'(pix_index));
        end
        if (frame_done) got_frames++;
    end

    int          model_q[$];
    logic [23:0] exp_pix[$];
    bit          exp_err;
    int          exp_frames;
    int          base_pix;
    int          base_frames;

    task automatic cycles_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
        model_q.push_back(h);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (w[i]) pulse(42, 20);
            else      pulse(20, 42);
        end
    endtask

    task automatic begin_frame();
        model_q.delete();
        base_pix    = got_data.size();
        base_frames = got_frames;
    endtask

    // Decode a frame from its list of high-pulse lengths.
    task automatic model_frame();
        logic [23:0] w;
        int nb;
        int acc;
        exp_pix.delete();
        exp_err = 1'b0;
        w = '0;
        nb = 0;
        acc = 0;
        foreach (model_q[i]) begin
            if (model_q[i] < MIN_H || model_q[i] > MAX_H) begin
                exp_err = 1'b1;
            end else begin
                w[nb] = (model_q[i] >= THR);
                nb++;
                acc++;
                if (nb == 24) begin
                    exp_pix.push_back(w);
                    w = '0;
                    nb = 0;
                end
            end
        end
        if (nb != 0) exp_err = 1'b1;
        exp_frames = (acc > 0) ? 1 : 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (pix_data !== 24'h0) begin n_fail++; $display("FAIL reset_pix_data got %h want 000000", pix_data); end
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
        n_checks++; if (pix_index !== 9'd0) begin n_fail++; $display("FAIL reset_pix_index got %0d want 0", pix_index); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        cycles_low(3000);
    endtask

    task automatic test_single_pixel();
        begin_frame();
        send_bits(24'h000001, 0, 23);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid got %b want 1", busy); end
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", got_data.size() - base_pix); end
        if (got_data.size() > base_pix) begin
            n_checks++; if (got_data[base_pix] !== 24'h000001) begin n_fail++; $display("FAIL single_data got %h want 000001", got_data[base_pix]); end
            n_checks++; if (got_idx[base_pix] !== 0) begin n_fail++; $display("FAIL single_index got %0d want 0", got_idx[base_pix]); end
        end
        n_checks++; if (got_frames - base_frames !== 1) begin n_fail++; $display("FAIL single_frames got %0d want 1", got_frames - base_frames); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
        n_checks++; if (pix_index !== 9'd0) begin n_fail++; $display("FAIL single_pix_index_end got %0d want 0", pix_index); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] words[3];
        words[0] = 24'hFF0000;
        words[1] = 24'h00FF00;
        words[2] = 24'h0000FF;
        begin_frame();
        for (int p = 0; p < 3; p++) send_bits(words[p], 0, 23);
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got_data.size() - base_pix); end
        for (int p = 0; p < 3 && base_pix + p < got_data.size(); p++) begin
            n_checks++; if (got_data[base_pix + p] !== words[p]) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", p, got_data[base_pix + p], words[p]); end
            n_checks++; if (got_idx[base_pix + p] !== p) begin n_fail++; $display("FAIL b2b_index%0d got %0d want %0d", p, got_idx[base_pix + p], p); end
        end
        n_checks++; if (got_frames - base_frames !== 1) begin n_fail++; $display("FAIL b2b_frames got %0d want 1", got_frames - base_frames); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b want 0", err); end
    endtask

    task automatic test_threshold();
        logic [23:0] w;
        w = ($urandom() & 24'hFFFFFE) | 24'h000002;
        begin_frame();
        for (int i = 0; i < 24; i++) begin
            if (w[i]) pulse(31, 25);
            else      pulse(30, 25);
        end
        cycles_low(3000);
        model_frame();
        n_checks++; if (got_data.size() - base_pix !== 1) begin n_fail++; $display("FAIL thresh_count got %0d want 1", got_data.size() - base_pix); end
        if (got_data.size() > base_pix) begin
            n_checks++; if (got_data[base_pix] !== w) begin n_fail++; $display("FAIL thresh_data got %h want %h", got_data[base_pix], w); end
        end
        n_checks++; if (err !== (ERR_EN & exp_err)) begin n_fail++; $display("FAIL thresh_err got %b want %b", err, ERR_EN & exp_err); end
    endtask

    task automatic test_glitch();
        logic [23:0] w;
        w = 24'($urandom());
        begin_frame();
        send_bits(w, 0, 7);
        pulse(5, 20);
        send_bits(w, 8, 23);
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", got_data.size() - base_pix); end
        if (got_data.size() > base_pix) begin
            n_checks++; if (got_data[base_pix] !== w) begin n_fail++; $display("FAIL glitch_data got %h want %h", got_data[base_pix], w); end
        end
        n_checks++; if (got_frames - base_frames !== 1) begin n_fail++; $display("FAIL glitch_frames got %0d want 1", got_frames - base_frames); end
        n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL glitch_err got %b want %b", err, ERR_EN); end
    endtask

    task automatic test_partial();
        begin_frame();
        send_bits(24'($urandom()), 0, 11);
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 0) begin n_fail++; $display("FAIL partial_count got %0d want 0", got_data.size() - base_pix); end
        n_checks++; if (got_frames - base_frames !== 1) begin n_fail++; $display("FAIL partial_frames got %0d want 1", got_frames - base_frames); end
        n_checks++; if (pix_index !== 9'd0) begin n_fail++; $display("FAIL partial_pix_index got %0d want 0", pix_index); end
        n_checks++; if (err !== ERR_EN) begin n_fail++; $display("FAIL partial_err got %b want %b", err, ERR_EN); end
    endtask

    task automatic test_random();
        int n;
        int r;
        int h;
        begin_frame();
        n = 48 + int'($urandom_range(0, 30));
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      h = int'($urandom_range(1, 9));
            else if (r == 1) h = int'($urandom_range(101, 130));
            else             h = int'($urandom_range(10, 100));
            pulse(h, int'($urandom_range(3, 60)));
        end
        cycles_low(3000);
        model_frame();
        n_checks++; if (got_data.size() - base_pix !== exp_pix.size()) begin n_fail++; $display("FAIL random_count got %0d want %0d", got_data.size() - base_pix, exp_pix.size()); end
        for (int p = 0; p < exp_pix.size() && base_pix + p < got_data.size(); p++) begin
            n_checks++; if (got_data[base_pix + p] !== exp_pix[p]) begin n_fail++; $display("FAIL random_data%0d got %h want %h", p, got_data[base_pix + p], exp_pix[p]); end
            n_checks++; if (got_idx[base_pix + p] !== p) begin n_fail++; $display("FAIL random_index%0d got %0d want %0d", p, got_idx[base_pix + p], p); end
        end
        n_checks++; if (got_frames - base_frames !== exp_frames) begin n_fail++; $display("FAIL random_frames got %0d want %0d", got_frames - base_frames, exp_frames); end
        if (exp_frames == 1) begin
            n_checks++; if (err !== (ERR_EN & exp_err)) begin n_fail++; $display("FAIL random_err got %b want %b", err, ERR_EN & exp_err); end
        end
    endtask

    task automatic test_rst_mid();
        logic [23:0] w;
        w = 24'($urandom());
        begin_frame();
        send_bits(w, 0, 9);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        rst = 1'b0;
        send_bits(~w, 0, 23);
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 0) begin n_fail++; $display("FAIL rstmid_nogap_count got %0d want 0", got_data.size() - base_pix); end
        n_checks++; if (got_frames - base_frames !== 0) begin n_fail++; $display("FAIL rstmid_nogap_frames got %0d want 0", got_frames - base_frames); end
        begin_frame();
        send_bits(w, 0, 23);
        cycles_low(3000);
        n_checks++; if (got_data.size() - base_pix !== 1) begin n_fail++; $display("FAIL rstmid_count got %0d want 1", got_data.size() - base_pix); end
        if (got_data.size() > base_pix) begin
            n_checks++; if (got_data[base_pix] !== w) begin n_fail++; $display("FAIL rstmid_data got %h want %h", got_data[base_pix], w); end
            n_checks++; if (got_idx[base_pix] !== 0) begin n_fail++; $display("FAIL rstmid_index got %0d want 0", got_idx[base_pix]); end
        end
        n_checks++; if (got_frames - base_frames !== 1) begin n_fail++; $display("FAIL rstmid_frames got %0d want 1", got_frames - base_frames); end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_threshold();
        test_glitch();
        test_partial();
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BIT_THRESH, default 31, high-time cycles at or above which a bit decodes as 1 (about 0.62 us).
REQ-003 SHALL have parameter MIN_HIGH, default 10, high pulses shorter than this are glitches.
REQ-004 SHALL have parameter MAX_HIGH, default 100, high pulses longer than this are malformed.
REQ-005 SHALL have parameter RESET_CYCLES, default CLK_FRE/20_000 (2500 = 50 us), low time that ends a frame.
REQ-006 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: din  input  1  asynchronous WS2812 serial line.
REQ-009 SHALL have port: pix_data  output  24  last completed pixel word.
REQ-010 SHALL have port: pix_valid  output  1  one-cycle strobe, pix_data/pix_index valid.
REQ-011 SHALL have port: pix_index  output  9  pixel position within the current frame, 0-based.
REQ-012 SHALL have port: frame_done  output  1  one-cycle strobe on detected reset gap after at least one bit.
REQ-013 SHALL have port: busy  output  1  high from the first rising edge of a frame until frame_done.
REQ-014 SHALL have port: err  output  1  sticky error flag, cleared by rst or by frame_done of an error-free frame.

Function
REQ-015 SHALL pass din through a 2-flop synchronizer; all timing below refers to the synchronized signal ds.
REQ-016 SHALL implement the states SYNC, IDLE, HIGH, LOW.
REQ-017 SYNC: count consecutive low cycles of ds, restart on high; SHALL move to IDLE on reaching RESET_CYCLES; no decode until then.
REQ-018 IDLE: on ds rising SHALL go to HIGH with high counter = 1.
REQ-019 HIGH: SHALL count cycles; on ds falling SHALL go to LOW with low counter = 1.
REQ-020 On the HIGH->LOW transition, a count below MIN_HIGH SHALL be discarded; otherwise the bit SHALL be (count >= BIT_THRESH).
REQ-021 The high counter SHALL saturate at MAX_HIGH+1; a pulse exceeding MAX_HIGH SHALL be discarded and shift in no bit.
REQ-022 Bit order: the first bit of each pixel on the wire SHALL be stored in pix_data[0], the 24th in pix_data[23] (LSB first).
REQ-023 The 24th accepted bit SHALL load pix_data and assert pix_valid for exactly one cycle, in the cycle after the falling edge is seen on ds.
REQ-024 pix_index SHALL equal the pixel's position in the frame; after each pix_valid it SHALL increment, wrapping from 511 to 0.
REQ-025 LOW: ds rising SHALL go to HIGH with high counter = 1; the low counter reaching RESET_CYCLES SHALL go to IDLE.
REQ-026 On the transition to IDLE, frame_done SHALL pulse one cycle; the bit counter and pix_index SHALL clear.
REQ-027 A partial pixel (1..23 bits) at frame end SHALL be discarded, with no pix_valid.
REQ-028 If pix_valid and frame_done would fall in the same cycle, pix_valid SHALL assert first and frame_done one cycle later.
REQ-029 Counters SHALL be sized to hold RESET_CYCLES without overflow.

Reset
REQ-030 On rst: state SYNC; pix_data 0; pix_valid 0; pix_index 0; frame_done 0; busy 0; err 0; counters and synchronizer 0.
REQ-031 rst asserted mid-pixel SHALL abandon the partial word without any strobe; after release, decode resumes only after a full reset gap.

Configuration
REQ-032 Macro WS2812_RX_ERR_EN defined: err SHALL set on a discarded glitch, a pulse longer than MAX_HIGH, or a partial pixel at frame end.
REQ-033 Macro WS2812_RX_ERR_EN undefined: err SHALL be tied 0 and error logic omitted; discard behaviour is unchanged.

Structure
REQ-034 The package ws2812_pkg SHALL hold the state enumeration, the 24-bit pixel width constant, and the default timing constants, shared with the transmitter.
REQ-035 The synchronizer plus edge detect SHALL be a sub-module ws2812_edge_sync (outputs ds, rise, fall).

Verification
REQ-036 Verification SHALL cover one pixel 24'h000001 sent with 42-cycle high/20-cycle low for a 1 and 20-cycle high/42-cycle low for a 0, 3000-cycle low before and after -> one pix_valid with pix_data=24'h000001, pix_index=0, then frame_done.
REQ-037 Verification SHALL cover three pixels 24'hFF0000, 24'h00FF00, 24'h0000FF back to back -> three pix_valid, pix_index 0,1,2, one frame_done, err=0.
REQ-038 Verification SHALL cover a 5-cycle high glitch between bits 7 and 8 -> pix_data unaffected; err=1 only with WS2812_RX_ERR_EN.
REQ-039 Verification SHALL cover 12 bits then a 3000-cycle low -> no pix_valid, frame_done pulses, pix_index=0; err=1 only with the macro.
REQ-040 Verification SHALL cover rst asserted at bit 10 and din driven with a full pixel right after release without a gap -> no pix_valid until a 2500-cycle low precedes the next pixel.
REQ-041 Verification SHALL cover 30-cycle and 31-cycle high pulses -> decoded as 0 and 1 respectively (threshold boundary).
